// File: rtl/us_delay_timer.sv
// us_delay_timer
// Converts the 1us tick from the tick generator into a programmable
// microsecond delay with a start/busy/done handshake. It also watches the
// spacing between ticks while running and aborts with a sticky err_gap flag
// when a tick goes missing.
//
// Handshake: start is sampled only in IDLE, where it is always accepted.
// len_us is captured in that same cycle. busy is high for every cycle spent
// in RUN. done is a single-cycle pulse that is raised only when the delay
// completes normally; an abort, a tick gap or a reset never raise it.
// start and len_us are ignored while busy.
module us_delay_timer #(
    parameter int          LEN_W   = 16,
    parameter logic [15:0] GAP_MAX = 16'd200
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             pluse_us,
    input  logic             start,
    input  logic [LEN_W-1:0] len_us,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] elapsed_us,
    output logic             err_gap,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]      GAP_LAST = GAP_MAX - 16'd1;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remain_q;
    logic [15:0]        gap_cnt_q;

    // Decoded actions for the datapath, produced by the next-state logic
    logic               accept;    // start taken in IDLE
    logic               count;     // tick counted in RUN
    logic               gap_inc;   // RUN cycle with no tick and no abort
    logic               gap_trip;  // tick gap exceeded, run abandoned

    assign dbg_state = state_q;

    // State register
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath-action decode; abort has priority over ticks
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        count    = 1'b0;
        gap_inc  = 1'b0;
        gap_trip = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (len_us != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pluse_us) begin
                    count = 1'b1;
                    if (remain_q == LEN_ONE) begin
                        state_d = ST_DONE;
                    end
                end else if (gap_cnt_q >= GAP_LAST) begin
                    gap_trip = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered handshake outputs, decoded from the next state
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == ST_RUN);
            done <= (state_d == ST_DONE);
        end
    end

    // Remaining/elapsed tick counters, tick-gap watchdog and sticky error
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            remain_q   <= '0;
            elapsed_us <= '0;
            gap_cnt_q  <= '0;
            err_gap    <= 1'b0;
        end else begin
            if (accept) begin
                remain_q   <= len_us;
                elapsed_us <= '0;
                gap_cnt_q  <= '0;
                err_gap    <= 1'b0;
            end
            if (count) begin
                remain_q  <= remain_q - LEN_ONE;
                gap_cnt_q <= '0;
                if (elapsed_us != '1) begin
                    elapsed_us <= elapsed_us + LEN_ONE;
                end
            end
            if (gap_inc && (gap_cnt_q != 16'hFFFF)) begin
                gap_cnt_q <= gap_cnt_q + 16'd1;
            end
            if (gap_trip) begin
                err_gap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_us_delay_timer.sv
// Directed bench for us_delay_timer with a shortened tick-gap limit.
module tb_us_delay_timer;

    localparam int LEN_W = 16;

    logic             clk_sys = 1'b0;
    logic             rst;
    logic             pluse_us;
    logic             start;
    logic [LEN_W-1:0] len_us;
    logic             abort;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] elapsed_us;
    logic             err_gap;
    logic [1:0]       dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    us_delay_timer #(.LEN_W(LEN_W), .GAP_MAX(16'd20)) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .pluse_us   (pluse_us),
        .start      (start),
        .len_us     (len_us),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .elapsed_us (elapsed_us),
        .err_gap    (err_gap),
        .dbg_state  (dbg_state)
    );

    // clock: 10 ns period
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one active edge; outputs are then sampled 1 ns after it
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // n quiet cycles: no done pulse, busy held at exp_busy
    task automatic quiet(input int n, input logic exp_busy, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_done"}, done, 1'b0);
            chk({tag, "_busy"}, busy, exp_busy);
        end
    endtask

    task automatic tick();
        pluse_us = 1'b1;
        step();
        pluse_us = 1'b0;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        start  = 1'b1;
        len_us = len;
        step();
        start  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pluse_us = 1'b0;
        start    = 1'b0;
        len_us   = '0;
        abort    = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_elapsed", elapsed_us, 0);
        chk("rst_err", err_gap, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        rst = 1'b0;

        // 1: len 3, ticks every 10 clks, start mid-gap
        quiet(4, 1'b0, "t1_pre");
        do_start(16'd3);
        chk("t1_busy_start", busy, 1'b1);
        chk("t1_state_run", dbg_state, 2'd1);
        chk("t1_elapsed_start", elapsed_us, 0);
        quiet(5, 1'b1, "t1_gapa");
        tick();
        chk("t1_el1", elapsed_us, 1);
        chk("t1_busy1", busy, 1'b1);
        quiet(9, 1'b1, "t1_gapb");
        tick();
        chk("t1_el2", elapsed_us, 2);
        quiet(9, 1'b1, "t1_gapc");
        tick();
        chk("t1_done", done, 1'b1);
        chk("t1_busy_done", busy, 1'b0);
        chk("t1_el3", elapsed_us, 3);
        step();
        chk("t1_done_1clk", done, 1'b0);
        chk("t1_el_hold", elapsed_us, 3);

        // 2: zero length completes immediately
        do_start(16'd0);
        chk("t2_done", done, 1'b1);
        chk("t2_busy", busy, 1'b0);
        chk("t2_el", elapsed_us, 0);
        quiet(2, 1'b0, "t2_post");

        // 3: tick in the start cycle is not counted
        pluse_us = 1'b1;
        do_start(16'd2);
        pluse_us = 1'b0;
        chk("t3_busy", busy, 1'b1);
        chk("t3_el0", elapsed_us, 0);
        quiet(3, 1'b1, "t3_gapa");
        tick();
        chk("t3_el1", elapsed_us, 1);
        chk("t3_busy1", busy, 1'b1);
        quiet(3, 1'b1, "t3_gapb");
        tick();
        chk("t3_done", done, 1'b1);
        chk("t3_el2", elapsed_us, 2);
        step();

        // 4a: abort after 2nd tick; restart with len 9 in RUN is ignored
        do_start(16'd5);
        do_start(16'd9);
        chk("t4a_busy_restart", busy, 1'b1);
        tick();
        quiet(2, 1'b1, "t4a_gap");
        tick();
        chk("t4a_el2", elapsed_us, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4a_busy", busy, 1'b0);
        chk("t4a_done", done, 1'b0);
        chk("t4a_el", elapsed_us, 2);
        quiet(3, 1'b0, "t4a_post");
        chk("t4a_el_hold", elapsed_us, 2);

        // 4b: abort in the same cycle as the completing 5th tick
        do_start(16'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            step();
        end
        chk("t4b_el4", elapsed_us, 4);
        pluse_us = 1'b1;
        abort    = 1'b1;
        step();
        pluse_us = 1'b0;
        abort    = 1'b0;
        chk("t4b_busy", busy, 1'b0);
        chk("t4b_done", done, 1'b0);
        chk("t4b_el", elapsed_us, 4);
        quiet(3, 1'b0, "t4b_post");

        // 4c: len 2 with a len 9 restart attempt still finishes after 2 ticks
        do_start(16'd2);
        do_start(16'd9);
        tick();
        tick();
        chk("t4c_done", done, 1'b1);
        chk("t4c_el", elapsed_us, 2);
        step();

        // 5: ticks stop after the first -> gap error 20 clks later
        do_start(16'd4);
        quiet(2, 1'b1, "t5_pre");
        tick();
        chk("t5_el1", elapsed_us, 1);
        quiet(19, 1'b1, "t5_gap");
        chk("t5_err_early", err_gap, 1'b0);
        step();
        chk("t5_err", err_gap, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_el", elapsed_us, 1);
        quiet(3, 1'b0, "t5_post");
        chk("t5_err_sticky", err_gap, 1'b1);
        do_start(16'd0);
        chk("t5_err_clr", err_gap, 1'b0);
        chk("t5_done_after", done, 1'b1);
        step();

        // 6: asynchronous reset while busy, then a normal run
        do_start(16'd3);
        tick();
        chk("t6_busy", busy, 1'b1);
        chk("t6_el1", elapsed_us, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_el", elapsed_us, 0);
        chk("t6_rst_err", err_gap, 1'b0);
        #1;
        rst = 1'b0;
        step();
        chk("t6_idle_done", done, 1'b0);
        do_start(16'd1);
        chk("t6_busy2", busy, 1'b1);
        quiet(1, 1'b1, "t6_gap");
        tick();
        chk("t6_done", done, 1'b1);
        chk("t6_busy_done", busy, 1'b0);
        chk("t6_el", elapsed_us, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
